// File: rtl/cpu_datapath.sv
// ---------------------------------------------------------------------------
// cpu_datapath
//   32-bit single-bus CPU datapath: 16 GPRs, HI/LO, PC, IR, Y, 64-bit Z,
//   MAR, MDR and a combinational ALU (A = Y, B = bus). All transfers are
//   driven by external strobes: xxout selects the bus source, and xxin
//   captures the bus on the next rising clock edge.
//
// Parameters
//   PC_RESET        value loaded into PC on reset
//
// Ports
//   i_clk, i_reset       clock, asynchronous active-high reset
//   i_R0out..i_R15out    GPR n drives the bus
//   i_HIout..i_MARout    special register / IN / sign-extended constant
//                        drives the bus
//   i_Read               MDR loads i_IN instead of the bus
//   i_IncPC              with i_PCin, PC loads PC+1
//   i_AND..i_NOT         ALU op selects (priority in port-list order)
//   i_R0in..i_R15in      GPR n loads the bus
//   i_HIin..i_MDRin      register load enables
//   i_IN                 memory-data / input-port value
//   o_BusMuxOut          current bus value
//   o_PC, o_PC_PLUS_1    PC register and PC+1
//
// Configuration
//   DATAPATH_DIV_EN      when defined, DIV is a signed divider
//                        (Zlow = quotient, Zhigh = remainder; divide by 0
//                        gives quotient all ones and remainder = A).
//                        When undefined, DIV selects a zero result.
// ---------------------------------------------------------------------------
module cpu_datapath #(
  parameter logic [31:0] PC_RESET = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_R0out,  input logic i_R1out,  input logic i_R2out,  input logic i_R3out,
  input  logic        i_R4out,  input logic i_R5out,  input logic i_R6out,  input logic i_R7out,
  input  logic        i_R8out,  input logic i_R9out,  input logic i_R10out, input logic i_R11out,
  input  logic        i_R12out, input logic i_R13out, input logic i_R14out, input logic i_R15out,
  input  logic        i_HIout,
  input  logic        i_LOout,
  input  logic        i_Zhighout,
  input  logic        i_Zlowout,
  input  logic        i_PCout,
  input  logic        i_IRout,
  input  logic        i_MDRout,
  input  logic        i_INout,
  input  logic        i_Cout,
  input  logic        i_Yout,
  input  logic        i_MARout,
  input  logic        i_Read,
  input  logic        i_IncPC,
  input  logic        i_AND,
  input  logic        i_OR,
  input  logic        i_ADD,
  input  logic        i_SUB,
  input  logic        i_MUL,
  input  logic        i_DIV,
  input  logic        i_SHR,
  input  logic        i_SHRA,
  input  logic        i_SHL,
  input  logic        i_ROR,
  input  logic        i_ROL,
  input  logic        i_NEG,
  input  logic        i_NOT,
  input  logic        i_R0in,  input logic i_R1in,  input logic i_R2in,  input logic i_R3in,
  input  logic        i_R4in,  input logic i_R5in,  input logic i_R6in,  input logic i_R7in,
  input  logic        i_R8in,  input logic i_R9in,  input logic i_R10in, input logic i_R11in,
  input  logic        i_R12in, input logic i_R13in, input logic i_R14in, input logic i_R15in,
  input  logic        i_HIin,
  input  logic        i_LOin,
  input  logic        i_PCin,
  input  logic        i_IRin,
  input  logic        i_Zin,
  input  logic        i_Yin,
  input  logic        i_MARin,
  input  logic        i_MDRin,
  input  logic [31:0] i_IN,
  output logic [31:0] o_BusMuxOut,
  output logic [31:0] o_PC,
  output logic [31:0] o_PC_PLUS_1
);

  logic [31:0] r_gpr [16];
  logic [31:0] r_hi, r_lo, r_pc, r_ir, r_y, r_mar, r_mdr;
  logic [63:0] r_z;

  logic [15:0] w_rOut, w_rIn;
  logic [31:0] w_bus, w_cSext, w_pcPlus1;
  logic [31:0] w_a, w_b;
  logic [4:0]  w_shamt;
  logic [31:0] w_shra;
  logic [63:0] w_mulProd;
  logic [63:0] w_divResult;
  logic [63:0] w_aluResult;

  assign w_rOut = {i_R15out, i_R14out, i_R13out, i_R12out, i_R11out, i_R10out, i_R9out, i_R8out,
                   i_R7out,  i_R6out,  i_R5out,  i_R4out,  i_R3out,  i_R2out,  i_R1out, i_R0out};
  assign w_rIn  = {i_R15in, i_R14in, i_R13in, i_R12in, i_R11in, i_R10in, i_R9in, i_R8in,
                   i_R7in,  i_R6in,  i_R5in,  i_R4in,  i_R3in,  i_R2in,  i_R1in, i_R0in};

  assign w_cSext   = {{13{r_ir[18]}}, r_ir[18:0]};
  assign w_pcPlus1 = r_pc + 32'd1;

  // Bus source mux. Sources are applied lowest priority first so the
  // highest-priority asserted strobe is the last write and wins.
  always_comb begin
    w_bus = '0;
    if (i_MARout)   w_bus = r_mar;
    if (i_Yout)     w_bus = r_y;
    if (i_IRout)    w_bus = r_ir;
    if (i_Cout)     w_bus = w_cSext;
    if (i_INout)    w_bus = i_IN;
    if (i_MDRout)   w_bus = r_mdr;
    if (i_PCout)    w_bus = r_pc;
    if (i_Zlowout)  w_bus = r_z[31:0];
    if (i_Zhighout) w_bus = r_z[63:32];
    if (i_LOout)    w_bus = r_lo;
    if (i_HIout)    w_bus = r_hi;
    for (int i = 15; i >= 0; i--) begin
      if (w_rOut[i]) w_bus = r_gpr[i];
    end
  end

  assign w_a       = r_y;
  assign w_b       = w_bus;
  assign w_shamt   = w_b[4:0];
  assign w_shra    = $signed(w_a) >>> w_shamt;
  assign w_mulProd = $signed({{32{w_a[31]}}, w_a}) * $signed({{32{w_b[31]}}, w_b});

`ifdef DATAPATH_DIV_EN
  // The divisor is replaced by 1 for divide-by-zero and for the single
  // overflow case (most-negative / -1), so the divider never sees an
  // undefined operation. For the overflow case A/1 = A and remainder 0
  // is exactly the wrapped two's-complement answer.
  logic        w_divOvf;
  logic [31:0] w_divSafeB;
  logic [31:0] w_divQ, w_divR;

  assign w_divOvf    = (w_a == 32'h8000_0000) && (w_b == 32'hFFFF_FFFF);
  assign w_divSafeB  = ((w_b == 32'h0) || w_divOvf) ? 32'd1 : w_b;
  assign w_divQ      = $signed(w_a) / $signed(w_divSafeB);
  assign w_divR      = $signed(w_a) % $signed(w_divSafeB);
  assign w_divResult = (w_b == 32'h0) ? {w_a, 32'hFFFF_FFFF} : {w_divR, w_divQ};
`else
  assign w_divResult = 64'h0;
`endif

  // ALU result select; 32-bit operations leave Z[63:32] zero.
  always_comb begin
    w_aluResult = 64'h0;
    if      (i_AND)  w_aluResult = {32'h0, w_a & w_b};
    else if (i_OR)   w_aluResult = {32'h0, w_a | w_b};
    else if (i_ADD)  w_aluResult = {32'h0, w_a + w_b};
    else if (i_SUB)  w_aluResult = {32'h0, w_a - w_b};
    else if (i_MUL)  w_aluResult = w_mulProd;
    else if (i_DIV)  w_aluResult = w_divResult;
    else if (i_SHR)  w_aluResult = {32'h0, w_a >> w_shamt};
    else if (i_SHRA) w_aluResult = {32'h0, w_shra};
    else if (i_SHL)  w_aluResult = {32'h0, w_a << w_shamt};
    else if (i_ROR)  w_aluResult = {32'h0, (w_a >> w_shamt) | (w_a << (6'd32 - {1'b0, w_shamt}))};
    else if (i_ROL)  w_aluResult = {32'h0, (w_a << w_shamt) | (w_a >> (6'd32 - {1'b0, w_shamt}))};
    else if (i_NEG)  w_aluResult = {32'h0, 32'h0 - w_b};
    else if (i_NOT)  w_aluResult = {32'h0, ~w_b};
  end

  // Register file and special registers; every load captures the bus
  // (or IN / PC+1 / ALU result) at the rising edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < 16; i++) r_gpr[i] <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_pc  <= PC_RESET;
      r_ir  <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (w_rIn[i]) r_gpr[i] <= w_bus;
      end
      if (i_HIin)  r_hi  <= w_bus;
      if (i_LOin)  r_lo  <= w_bus;
      if (i_PCin)  r_pc  <= i_IncPC ? w_pcPlus1 : w_bus;
      if (i_IRin)  r_ir  <= w_bus;
      if (i_Yin)   r_y   <= w_bus;
      if (i_Zin)   r_z   <= w_aluResult;
      if (i_MARin) r_mar <= w_bus;
      if (i_MDRin) r_mdr <= i_Read ? i_IN : w_bus;
    end
  end

  assign o_BusMuxOut = w_bus;
  assign o_PC        = r_pc;
  assign o_PC_PLUS_1 = w_pcPlus1;

endmodule

// File: tb/tb_cpu_datapath.sv
// ---------------------------------------------------------------------------
// tb_cpu_datapath
//   Self-checking bench for cpu_datapath. A register-level model of the
//   datapath (plain arrays and integer arithmetic) tracks every register;
//   a compare process checks bus, PC and PC+1 on every falling edge, and
//   directed sequences pin the model with hand-computed values.
//   Honours DATAPATH_DIV_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_cpu_datapath;

  localparam int S_HI = 0, S_LO = 1, S_ZH = 2, S_ZL = 3, S_PC = 4, S_MDR = 5,
                 S_IN = 6, S_C = 7, S_IR = 8, S_Y = 9, S_MAR = 10;
  localparam int L_HI = 0, L_LO = 1, L_PC = 2, L_IR = 3, L_Z = 4, L_Y = 5,
                 L_MAR = 6, L_MDR = 7;
  localparam int O_AND = 0, O_OR = 1, O_ADD = 2, O_SUB = 3, O_MUL = 4, O_DIV = 5,
                 O_SHR = 6, O_SHRA = 7, O_SHL = 8, O_ROR = 9, O_ROL = 10,
                 O_NEG = 11, O_NOT = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rOut, rIn;
  logic [10:0] sOut;
  logic [12:0] op;
  logic [7:0]  ld;
  logic        read, incPc;
  logic [31:0] inVal;
  logic [31:0] busOut, pcOut, pcPlus1Out;

  int  total = 0;
  int  bad   = 0;
  bit  checkEn = 1'b0;

  logic [31:0] mR [16];
  logic [31:0] mHi, mLo, mPc, mIr, mY, mMar, mMdr;
  logic [63:0] mZ;

  always #5 clk = ~clk;

  cpu_datapath dut (
    .i_clk(clk), .i_reset(reset),
    .i_R0out(rOut[0]),   .i_R1out(rOut[1]),   .i_R2out(rOut[2]),   .i_R3out(rOut[3]),
    .i_R4out(rOut[4]),   .i_R5out(rOut[5]),   .i_R6out(rOut[6]),   .i_R7out(rOut[7]),
    .i_R8out(rOut[8]),   .i_R9out(rOut[9]),   .i_R10out(rOut[10]), .i_R11out(rOut[11]),
    .i_R12out(rOut[12]), .i_R13out(rOut[13]), .i_R14out(rOut[14]), .i_R15out(rOut[15]),
    .i_HIout(sOut[S_HI]), .i_LOout(sOut[S_LO]), .i_Zhighout(sOut[S_ZH]), .i_Zlowout(sOut[S_ZL]),
    .i_PCout(sOut[S_PC]), .i_IRout(sOut[S_IR]), .i_MDRout(sOut[S_MDR]), .i_INout(sOut[S_IN]),
    .i_Cout(sOut[S_C]), .i_Yout(sOut[S_Y]), .i_MARout(sOut[S_MAR]),
    .i_Read(read), .i_IncPC(incPc),
    .i_AND(op[O_AND]), .i_OR(op[O_OR]), .i_ADD(op[O_ADD]), .i_SUB(op[O_SUB]),
    .i_MUL(op[O_MUL]), .i_DIV(op[O_DIV]), .i_SHR(op[O_SHR]), .i_SHRA(op[O_SHRA]),
    .i_SHL(op[O_SHL]), .i_ROR(op[O_ROR]), .i_ROL(op[O_ROL]), .i_NEG(op[O_NEG]),
    .i_NOT(op[O_NOT]),
    .i_R0in(rIn[0]),   .i_R1in(rIn[1]),   .i_R2in(rIn[2]),   .i_R3in(rIn[3]),
    .i_R4in(rIn[4]),   .i_R5in(rIn[5]),   .i_R6in(rIn[6]),   .i_R7in(rIn[7]),
    .i_R8in(rIn[8]),   .i_R9in(rIn[9]),   .i_R10in(rIn[10]), .i_R11in(rIn[11]),
    .i_R12in(rIn[12]), .i_R13in(rIn[13]), .i_R14in(rIn[14]), .i_R15in(rIn[15]),
    .i_HIin(ld[L_HI]), .i_LOin(ld[L_LO]), .i_PCin(ld[L_PC]), .i_IRin(ld[L_IR]),
    .i_Zin(ld[L_Z]), .i_Yin(ld[L_Y]), .i_MARin(ld[L_MAR]), .i_MDRin(ld[L_MDR]),
    .i_IN(inVal),
    .o_BusMuxOut(busOut), .o_PC(pcOut), .o_PC_PLUS_1(pcPlus1Out)
  );

  // Bus value implied by the model: first asserted source in priority order.
  function automatic logic [31:0] busModel();
    logic [31:0] vals [11];
    vals[S_HI]  = mHi;          vals[S_LO] = mLo;
    vals[S_ZH]  = mZ[63:32];    vals[S_ZL] = mZ[31:0];
    vals[S_PC]  = mPc;          vals[S_MDR] = mMdr;
    vals[S_IN]  = inVal;
    vals[S_C]   = {{13{mIr[18]}}, mIr[18:0]};
    vals[S_IR]  = mIr;          vals[S_Y] = mY;
    vals[S_MAR] = mMar;
    for (int i = 0; i < 16; i++) if (rOut[i]) return mR[i];
    for (int j = 0; j < 11; j++) if (sOut[j]) return vals[j];
    return 32'h0;
  endfunction

  // ALU result from the arithmetic definition of each operation.
  function automatic logic [63:0] aluModel(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p;
    logic [31:0] v;
    int s;
    int k;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = int'(b % 32);
    k  = -1;
    for (int i = 12; i >= 0; i--) if (op[i]) k = i;
    v = a;
    case (k)
      O_AND:  return {32'h0, a & b};
      O_OR:   return {32'h0, a | b};
      O_ADD:  return {32'h0, 32'(sa + sb)};
      O_SUB:  return {32'h0, 32'(sa - sb)};
      O_MUL:  begin p = sa * sb; return 64'(p); end
      O_DIV: begin
`ifdef DATAPATH_DIV_EN
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
`else
        return 64'h0;
`endif
      end
      O_SHR:  return {32'h0, a >> s};
      O_SHRA: begin for (int i = 0; i < s; i++) v = {v[31], v[31:1]}; return {32'h0, v}; end
      O_SHL:  return {32'h0, a << s};
      O_ROR:  begin for (int i = 0; i < s; i++) v = {v[0], v[31:1]}; return {32'h0, v}; end
      O_ROL:  begin for (int i = 0; i < s; i++) v = {v[30:0], v[31]}; return {32'h0, v}; end
      O_NEG:  return {32'h0, 32'(-sb)};
      O_NOT:  return {32'h0, ~b};
      default: return 64'h0;
    endcase
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 16; i++) mR[i] = 32'h0;
    mHi = 0; mLo = 0; mPc = 0; mIr = 0; mY = 0; mMar = 0; mMdr = 0; mZ = 0;
  endtask

  task automatic updateModel();
    logic [31:0] b;
    logic [63:0] z;
    b = busModel();
    z = aluModel(mY, b);
    for (int i = 0; i < 16; i++) if (rIn[i]) mR[i] = b;
    if (ld[L_HI])  mHi  = b;
    if (ld[L_LO])  mLo  = b;
    if (ld[L_PC])  mPc  = incPc ? mPc + 32'd1 : b;
    if (ld[L_IR])  mIr  = b;
    if (ld[L_Y])   mY   = b;
    if (ld[L_Z])   mZ   = z;
    if (ld[L_MAR]) mMar = b;
    if (ld[L_MDR]) mMdr = read ? inVal : b;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearCtl();
    rOut = 0; rIn = 0; sOut = 0; op = 0; ld = 0;
    read = 0; incPc = 0; inVal = 0;
  endtask

  // One clock: outputs are compared at the falling edge, model follows
  // the rising edge, controls are released just after it.
  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
    updateModel();
    #1;
    clearCtl();
  endtask

  task automatic peek(input string name, input logic [31:0] expected);
    #1;
    checkOutput(name, busOut, expected);
  endtask

  task automatic loadMdr(input logic [31:0] v);
    inVal = v; read = 1; ld[L_MDR] = 1;
    cycle();
  endtask

  task automatic applyStimulus();
    int mode, idx;
    clearCtl();
    mode = $urandom_range(0, 9);
    for (int n = 0; n < (mode >= 8 ? 2 : (mode == 0 ? 0 : 1)); n++) begin
      idx = $urandom_range(0, 26);
      if (idx < 16) rOut[idx] = 1; else sOut[idx - 16] = 1;
    end
    for (int i = 0; i < 16; i++) rIn[i] = ($urandom_range(0, 7) == 0);
    for (int i = 0; i < 8; i++)  ld[i]  = ($urandom_range(0, 3) == 0);
    mode = $urandom_range(0, 15);
    if (mode < 13) op[mode] = 1;
    else if (mode > 13) begin
      op[$urandom_range(0, 12)] = 1;
      op[$urandom_range(0, 12)] = 1;
    end
    read  = $urandom_range(0, 1);
    incPc = $urandom_range(0, 1);
    case ($urandom_range(0, 5))
      0: inVal = 32'h0;
      1: inVal = 32'hFFFF_FFFF;
      2: inVal = $urandom_range(0, 40);
      default: inVal = $urandom;
    endcase
    cycle();
  endtask

  // Per-cycle comparison of every observable output against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("bus", busOut, busModel());
      checkOutput("pc", pcOut, mPc);
      checkOutput("pc_plus_1", pcPlus1Out, mPc + 32'd1);
    end
  end

  initial begin
    clearCtl();
    reset = 1;
    resetModel();
    repeat (2) @(posedge clk);
    #1 reset = 0;
    checkEn = 1;

    rOut[5] = 1;
    peek("reset_r5", 32'h0);
    checkOutput("reset_pc", pcOut, 32'h0);
    checkOutput("reset_pc_plus_1", pcPlus1Out, 32'h1);
    rOut = 0;

    loadMdr(32'h22); sOut[S_MDR] = 1; rIn[3] = 1; cycle();
    loadMdr(32'h24); sOut[S_MDR] = 1; rIn[7] = 1; cycle();
    rOut[3] = 1; peek("r3", 32'h22); rOut = 0;
    rOut[7] = 1; peek("r7", 32'h24); rOut = 0;

    rOut[3] = 1; ld[L_Y] = 1; cycle();
    rOut[7] = 1; op[O_SHR] = 1; ld[L_Z] = 1; cycle();
    sOut[S_ZL] = 1; rIn[4] = 1; cycle();
    rOut[4] = 1; peek("shr_r4", 32'h2); rOut = 0;

    inVal = 32'h2A2B_8000; read = 1; incPc = 1;
    ld[L_PC] = 1; ld[L_MAR] = 1; ld[L_MDR] = 1; cycle();
    checkOutput("fetch_pc", pcOut, 32'h1);
    checkOutput("fetch_pc_plus_1", pcPlus1Out, 32'h2);
    sOut[S_MDR] = 1; peek("fetch_mdr", 32'h2A2B_8000);
    ld[L_IR] = 1; cycle();
    sOut[S_IR] = 1; peek("fetch_ir", 32'h2A2B_8000); sOut = 0;
    sOut[S_C] = 1; peek("c_pos", 32'h0003_8000); sOut = 0;

    loadMdr(32'h0004_0001); sOut[S_MDR] = 1; ld[L_IR] = 1; cycle();
    sOut[S_C] = 1; peek("c_neg", 32'hFFFC_0001); sOut = 0;

    loadMdr(32'hFFFF_FFFD); sOut[S_MDR] = 1; ld[L_Y] = 1; cycle();
    loadMdr(32'h7); sOut[S_MDR] = 1; op[O_MUL] = 1; ld[L_Z] = 1; cycle();
    sOut[S_ZH] = 1; peek("mul_hi", 32'hFFFF_FFFF); sOut = 0;
    sOut[S_ZL] = 1; peek("mul_lo", 32'hFFFF_FFEB); sOut = 0;

    ld[L_Z] = 1; cycle();
    sOut[S_ZL] = 1; peek("zin_noop", 32'h0); sOut = 0;

    loadMdr(32'h7); sOut[S_MDR] = 1; ld[L_Y] = 1; cycle();
    loadMdr(32'hFFFF_FFFE); sOut[S_MDR] = 1; op[O_DIV] = 1; ld[L_Z] = 1; cycle();
`ifdef DATAPATH_DIV_EN
    sOut[S_ZL] = 1; peek("div_quot", 32'hFFFF_FFFD); sOut = 0;
    sOut[S_ZH] = 1; peek("div_rem", 32'h1); sOut = 0;
    op[O_DIV] = 1; ld[L_Z] = 1; cycle();
    sOut[S_ZL] = 1; peek("div0_quot", 32'hFFFF_FFFF); sOut = 0;
    sOut[S_ZH] = 1; peek("div0_rem", 32'h7); sOut = 0;
`else
    sOut[S_ZL] = 1; peek("div_off_lo", 32'h0); sOut = 0;
    sOut[S_ZH] = 1; peek("div_off_hi", 32'h0); sOut = 0;
`endif

    loadMdr(32'hFFFF_FFFF); sOut[S_MDR] = 1; ld[L_Y] = 1; cycle();
    loadMdr(32'h2); sOut[S_MDR] = 1; op[O_ADD] = 1; ld[L_Z] = 1; cycle();
    sOut[S_ZL] = 1; peek("add_wrap", 32'h1); sOut = 0;

    loadMdr(32'h11); sOut[S_MDR] = 1; rIn[1] = 1; cycle();
    loadMdr(32'h12); sOut[S_MDR] = 1; rIn[2] = 1; cycle();
    rOut[1] = 1; rOut[2] = 1; peek("prio_r1_r2", 32'h11); rOut = 0;
    peek("no_outs", 32'h0);

    for (int n = 0; n < 400; n++) applyStimulus();

    loadMdr(32'h55); sOut[S_MDR] = 1; ld[L_PC] = 1; cycle();
    checkOutput("pc_before_reset", pcOut, 32'h55);
    sOut[S_MDR] = 1;
    #1 reset = 1;
    resetModel();
    #1;
    checkOutput("midrun_bus", busOut, 32'h0);
    checkOutput("midrun_pc", pcOut, 32'h0);
    #1 reset = 0;
    sOut = 0;

    for (int n = 0; n < 100; n++) applyStimulus();

    checkEn = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
